output_stream_unit: RTL and testbench

Downstream consumer of the pipelined CPU's output port. It captures every WIDTH-bit result word presented on the CPU's out bus in cycles where outFlag is high, and buffers the words in a small synchronous FIFO. It then serializes each word, most-significant byte first, onto an 8-bit valid/ready byte stream for a host link such as a UART TX or debug bridge.

---
 rtl/cpu_io_pkg.sv | 16 +
 rtl/output_stream_unit_sync_fifo.sv | 56 +++++
 rtl/output_stream_unit.sv | 128 ++++++++++++
 tb/tb_output_stream_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU output-port consumer.
package cpu_io_pkg;

    localparam int BYTEWIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } streamState_t;

    // Number of host-stream bytes needed to carry one CPU word.
    function automatic int bytesPerWord(input int width);
        return width / BYTEWIDTH;
    endfunction

endpackage

// File: rtl/output_stream_unit_sync_fifo.sv
// Small synchronous word FIFO; push/pop arrive already qualified by the owner.
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int PTRWIDTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    dataIn,
    output logic [WIDTH-1:0]    headData,
    output logic                full,
    output logic                empty,
    output logic [PTRWIDTH:0]   count
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTRWIDTH-1:0] wrPtr;
    logic [PTRWIDTH-1:0] rdPtr;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= dataIn;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign headData = mem[rdPtr];
    assign full     = (count == (PTRWIDTH + 1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/output_stream_unit.sv
// Captures CPU output words into a FIFO and serializes them MSB byte first
// onto a registered valid/ready byte stream.
module output_stream_unit
    import cpu_io_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int PTRWIDTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                outFlag,
    input  logic [WIDTH-1:0]    out,
    input  logic                clearOverflow,
    output logic [7:0]          byteData,
    output logic                byteValid,
    input  logic                byteReady,
    output logic                full,
    output logic                empty,
    output logic [PTRWIDTH:0]   count,
    output logic                overflow
);

    localparam int BPW  = bytesPerWord(WIDTH);
    localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDXW-1:0] LASTIDX = IDXW'(BPW - 1);

    streamState_t     state, stateNext;
    logic [WIDTH-1:0] holding, holdingNext;
    logic [IDXW-1:0]  byteIdx, byteIdxNext;
    logic [7:0]       byteDataNext;
    logic             byteValidNext;
    logic [WIDTH-1:0] headData;
    logic [WIDTH-1:0] shifted;
    logic             popReq;
    logic             pushReq;
    logic             drop;

    // A same-edge pop frees a slot, so a full FIFO can still accept the word.
    assign pushReq = outFlag && (!full || popReq);
    assign drop    = outFlag && full && !popReq;

    sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PTRWIDTH (PTRWIDTH)
    ) fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (pushReq),
        .pop      (popReq),
        .dataIn   (out),
        .headData (headData),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Serializer next-state: byte outputs are computed from the next holding
    // word and index so they can be registered without a byteReady path.
    always_comb begin
        stateNext     = state;
        holdingNext   = holding;
        byteIdxNext   = byteIdx;
        popReq        = 1'b0;
        byteValidNext = byteValid;
        byteDataNext  = byteData;
        shifted       = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    popReq      = 1'b1;
                    holdingNext = headData;
                    byteIdxNext = '0;
                    stateNext   = SEND;
                end
            end
            SEND: begin
                if (byteReady) begin
                    if (byteIdx != LASTIDX) begin
                        byteIdxNext = byteIdx + 1'b1;
                    end else if (!empty) begin
                        popReq      = 1'b1;
                        holdingNext = headData;
                        byteIdxNext = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        byteValidNext = (stateNext == SEND);
        if (stateNext == SEND) begin
            shifted      = holdingNext << (BYTEWIDTH * int'(byteIdxNext));
            byteDataNext = shifted[WIDTH-1 -: BYTEWIDTH];
        end
    end

    // Serializer state and registered stream outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            holding   <= '0;
            byteIdx   <= '0;
            byteValid <= 1'b0;
            byteData  <= '0;
        end else begin
            state     <= stateNext;
            holding   <= holdingNext;
            byteIdx   <= byteIdxNext;
            byteValid <= byteValidNext;
            byteData  <= byteDataNext;
        end
    end

    // Sticky drop flag; a drop on the clearing edge keeps it set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clearOverflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_stream_unit.sv
// Directed, table-driven bench for output_stream_unit.
module tb_output_stream_unit;

    logic        clock;
    logic        reset;
    logic        outFlag;
    logic [15:0] out;
    logic        clearOverflow;
    logic [7:0]  byteData;
    logic        byteValid;
    logic        byteReady;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        oFlag;
        logic [15:0] word;
        logic        rdy;
        logic        clr;
        logic        expValid;
        logic [7:0]  expData;
        logic [3:0]  expCount;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    output_stream_unit #(
        .WIDTH    (16),
        .DEPTH    (8),
        .PTRWIDTH (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .outFlag       (outFlag),
        .out           (out),
        .clearOverflow (clearOverflow),
        .byteData      (byteData),
        .byteValid     (byteValid),
        .byteReady     (byteReady),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic addVec(input logic oFlag, input logic [15:0] word, input logic rdy,
                          input logic clr, input logic expValid, input logic [7:0] expData,
                          input logic [3:0] expCount, input logic expOvf);
        vec_t v;
        v.oFlag = oFlag; v.word = word; v.rdy = rdy; v.clr = clr;
        v.expValid = expValid; v.expData = expData;
        v.expCount = expCount; v.expOvf = expOvf;
        vecs.push_back(v);
    endtask

    task automatic checkState(input string name, input int idx, input logic v,
                              input logic [7:0] d, input logic [3:0] c, input logic o);
        check({name, ".valid"}, idx, 32'(byteValid), 32'(v));
        if (v) check({name, ".data"}, idx, 32'(byteData), 32'(d));
        check({name, ".count"}, idx, 32'(count), 32'(c));
        check({name, ".full"}, idx, 32'(full), 32'(c == 4'd8));
        check({name, ".empty"}, idx, 32'(empty), 32'(c == 4'd0));
        check({name, ".ovf"}, idx, 32'(overflow), 32'(o));
    endtask

    initial begin
        logic [15:0] drainWords [8];
        logic [3:0]  cnt;
        int waited;

        // Single word 0xABCD with byteReady held high.
        addVec(1, 16'hABCD, 1, 0, 0, 8'h00, 4'd1, 0);
        addVec(0, 16'h0000, 1, 0, 1, 8'hAB, 4'd0, 0);
        addVec(0, 16'h0000, 1, 0, 1, 8'hCD, 4'd0, 0);
        addVec(0, 16'h0000, 1, 0, 0, 8'h00, 4'd0, 0);
        // Fill with byteReady low: 0x0001 goes to holding, 2..9 fill, 0x000A dropped.
        addVec(1, 16'h0001, 0, 0, 0, 8'h00, 4'd1, 0);
        addVec(1, 16'h0002, 0, 0, 1, 8'h00, 4'd1, 0);
        for (int w = 3; w <= 9; w++)
            addVec(1, 16'(w), 0, 0, 1, 8'h00, 4'(w - 1), 0);
        addVec(1, 16'h000A, 0, 0, 1, 8'h00, 4'd8, 1);
        // Drop and clear on the same edge: set wins; then clear alone.
        addVec(1, 16'h000B, 0, 1, 1, 8'h00, 4'd8, 1);
        addVec(0, 16'h0000, 0, 1, 1, 8'h00, 4'd8, 0);
        // Full FIFO, push on the edge completing the last byte: accepted.
        addVec(0, 16'h0000, 1, 0, 1, 8'h01, 4'd8, 0);
        addVec(1, 16'h00CC, 1, 0, 1, 8'h00, 4'd8, 0);
        addVec(0, 16'h0000, 1, 0, 1, 8'h02, 4'd8, 0);
        // Drain 0x0003..0x0009 then 0x00CC back to back.
        drainWords = '{16'h0003, 16'h0004, 16'h0005, 16'h0006,
                       16'h0007, 16'h0008, 16'h0009, 16'h00CC};
        cnt = 4'd8;
        for (int w = 0; w < 8; w++) begin
            cnt = cnt - 4'd1;
            addVec(0, 16'h0000, 1, 0, 1, drainWords[w][15:8], cnt, 0);
            addVec(0, 16'h0000, 1, 0, 1, drainWords[w][7:0], cnt, 0);
        end
        addVec(0, 16'h0000, 1, 0, 0, 8'h00, 4'd0, 0);

        reset = 1'b0; outFlag = 1'b0; out = '0; clearOverflow = 1'b0; byteReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkState("reset", 0, 0, 8'h00, 4'd0, 0);
        check("reset.data", 0, 32'(byteData), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            outFlag = vecs[i].oFlag; out = vecs[i].word;
            byteReady = vecs[i].rdy; clearOverflow = vecs[i].clr;
            @(posedge clock);
            #1;
            checkState("vec", i, vecs[i].expValid, vecs[i].expData,
                       vecs[i].expCount, vecs[i].expOvf);
        end
        outFlag = 1'b0; clearOverflow = 1'b0;

        // Backpressure: 0x1234 held for 5 cycles with byteReady low.
        byteReady = 1'b0; outFlag = 1'b1; out = 16'h1234;
        @(posedge clock); #1;
        outFlag = 1'b0;
        checkState("bp.cap", 0, 0, 8'h00, 4'd1, 0);
        @(posedge clock); #1;
        checkState("bp.pop", 0, 1, 8'h12, 4'd0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checkState("bp.hold", i, 1, 8'h12, 4'd0, 0);
        end
        byteReady = 1'b1;
        @(posedge clock); #1;
        checkState("bp.lo", 0, 1, 8'h34, 4'd0, 0);
        @(posedge clock); #1;
        checkState("bp.done", 0, 0, 8'h00, 4'd0, 0);

        // Reset mid-transfer with 0xBEEF on the bus and three words buffered.
        byteReady = 1'b0; outFlag = 1'b1; out = 16'hBEEF;
        @(posedge clock); #1;
        out = 16'h1111;
        @(posedge clock); #1;
        checkState("rst.first", 0, 1, 8'hBE, 4'd1, 0);
        out = 16'h2222;
        @(posedge clock); #1;
        out = 16'h3333;
        @(posedge clock); #1;
        outFlag = 1'b0;
        checkState("rst.buf", 0, 1, 8'hBE, 4'd3, 0);
        #2 reset = 1'b0;
        #1;
        checkState("rst.async", 0, 0, 8'h00, 4'd0, 0);
        check("rst.data", 0, 32'(byteData), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        byteReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            checkState("rst.quiet", i, 0, 8'h00, 4'd0, 0);
        end
        outFlag = 1'b1; out = 16'h5A5B;
        @(posedge clock); #1;
        outFlag = 1'b0;
        waited = 0;
        while (!byteValid && waited < 8) begin
            @(posedge clock); #1;
            waited++;
        end
        check("rst.latency", 0, 32'(waited), 32'd1);
        check("rst.hi", 0, 32'(byteData), 32'h5A);
        @(posedge clock); #1;
        checkState("rst.lo", 0, 1, 8'h5B, 4'd0, 0);
        @(posedge clock); #1;
        checkState("rst.end", 0, 0, 8'h00, 4'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
